phys_freelist: RTL and testbench

Circular free list of physical register tags for the rename stage. Hands out up to two free tags per cycle to the renamer, and those grants drive the busy-bit table's clear inputs (`freelist_en`, `next_free`). Tags released at commit are taken back, and the speculative allocation state is restored on branch or exception recovery. The block is instantiated twice: once for GPRs (32 physical, 16 architectural) and once for T-bits (16 physical, 1 architectural).

---
 rtl/phys_freelist_pkg.sv | 19 +
 rtl/phys_freelist.sv | 132 +++++++++++++
 tb/tb_phys_freelist.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phys_freelist_pkg.sv
// Shared rename-stage constants and tag types for the physical-register free lists.
package phys_freelist_pkg;

    localparam int unsigned NUM_PREGS_GPR = 32;
    localparam int unsigned NUM_AREGS_GPR = 16;
    localparam int unsigned NUM_PREGS_T   = 16;
    localparam int unsigned NUM_AREGS_T   = 1;

    localparam int unsigned PREG_TAG_W = $clog2(NUM_PREGS_GPR);
    localparam int unsigned T_TAG_W    = $clog2(NUM_PREGS_T);

    typedef logic [PREG_TAG_W-1:0] preg_tag_t;
    typedef logic [T_TAG_W-1:0]    t_tag_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/phys_freelist.sv
// Circular free list of physical tags: two-wide allocate, two-wide release,
// committed-head snapshot for branch/exception recovery.
module phys_freelist
    import phys_freelist_pkg::*;
#(
    parameter int unsigned NUM_PREGS = NUM_PREGS_GPR,
    parameter int unsigned NUM_AREGS = NUM_AREGS_GPR,
    parameter int unsigned TAG_W     = $clog2(NUM_PREGS)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      recovery_en,
    input  logic [1:0]                                alloc_req,
    output logic [1:0]                                freelist_en,
    output logic [1:0][TAG_W-1:0]                     next_free,
    output logic                                      alloc_stall,
    input  logic [1:0]                                commit_en,
    input  logic [1:0][TAG_W-1:0]                     commit_tag,
    input  logic [1:0]                                commit_alloc,
    output logic [$clog2(NUM_PREGS-NUM_AREGS+1)-1:0]  free_count,
    output logic                                      overflow_err
);

    localparam int unsigned DEPTH  = NUM_PREGS - NUM_AREGS;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PSUM_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] arch_head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] spec_count;
    logic [CNT_W-1:0] arch_count;

    // Pointer advance by 0..2 with explicit wrap; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
        logic [PSUM_W-1:0] s;
        s = {1'b0, p} + PSUM_W'(n);
        if (s >= PSUM_W'(DEPTH)) begin
            s = s - PSUM_W'(DEPTH);
        end
        return s[PTR_W-1:0];
    endfunction

    logic [1:0]       n_req;
    logic [1:0]       n_grant;
    logic [PTR_W-1:0] head_p1;
    logic             grant_ok;

    // Zero-latency grant from registered state; slot 1 takes the head when slot 0 is idle.
    always_comb begin
        n_req       = popcount2(alloc_req);
        head_p1     = ptr_add(spec_head, 2'd1);
        alloc_stall = (CNT_W'(n_req) > spec_count);
        grant_ok    = !recovery_en && !alloc_stall;
        freelist_en = grant_ok ? alloc_req : 2'b00;
        n_grant     = grant_ok ? n_req : 2'd0;
        next_free[0] = mem[spec_head];
        next_free[1] = (alloc_req == 2'b10) ? mem[spec_head] : mem[head_p1];
    end

    logic [1:0]       n_cal;
    logic [1:0]       n_push;
    logic [SUM_W-1:0] room;
    logic             push0;
    logic             push1;
    logic             ovf_set;
    logic [PTR_W-1:0] wr1_ptr;
    logic [PTR_W-1:0] tail_nxt;
    logic [PTR_W-1:0] arch_head_nxt;
    logic [PTR_W-1:0] spec_head_nxt;
    logic [CNT_W-1:0] arch_count_nxt;
    logic [CNT_W-1:0] spec_count_nxt;

    // Release room counts entries retiring this cycle, so a commit that frees and
    // retires together never overflows a full list.
    always_comb begin
        n_cal   = popcount2(commit_alloc);
        room    = SUM_W'(DEPTH) - SUM_W'(arch_count) + SUM_W'(n_cal);
        push0   = commit_en[0] && (room != '0);
        push1   = commit_en[1] && (room > SUM_W'(push0));
        ovf_set = (commit_en[0] && !push0) || (commit_en[1] && !push1);
        n_push  = {1'b0, push0} + {1'b0, push1};
        wr1_ptr = push0 ? ptr_add(tail, 2'd1) : tail;

        tail_nxt       = ptr_add(tail, n_push);
        arch_head_nxt  = ptr_add(arch_head, n_cal);
        arch_count_nxt = CNT_W'(SUM_W'(arch_count) + SUM_W'(n_push) - SUM_W'(n_cal));

        if (recovery_en) begin
            spec_head_nxt  = arch_head_nxt;
            spec_count_nxt = arch_count_nxt;
        end else begin
            spec_head_nxt  = ptr_add(spec_head, n_grant);
            spec_count_nxt = CNT_W'(SUM_W'(spec_count) + SUM_W'(n_push) - SUM_W'(n_grant));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(NUM_AREGS + i);
            end
            spec_head    <= '0;
            arch_head    <= '0;
            tail         <= '0;
            spec_count   <= CNT_W'(DEPTH);
            arch_count   <= CNT_W'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (push0) begin
                mem[tail] <= commit_tag[0];
            end
            if (push1) begin
                mem[wr1_ptr] <= commit_tag[1];
            end
            spec_head  <= spec_head_nxt;
            arch_head  <= arch_head_nxt;
            tail       <= tail_nxt;
            spec_count <= spec_count_nxt;
            arch_count <= arch_count_nxt;
            if (ovf_set) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign free_count = spec_count;

endmodule

// File: tb/tb_phys_freelist.sv
// Bench for phys_freelist: GPR and T-bit instances checked against a queue model.
module tb_phys_freelist;
    import phys_freelist_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            g_rec, g_stall, g_ovf;
    logic [1:0]      g_req, g_en, g_cen, g_cal;
    preg_tag_t [1:0] g_nf, g_ctag;
    logic [4:0]      g_cnt;

    logic            t_rec, t_stall, t_ovf;
    logic [1:0]      t_req, t_en, t_cen, t_cal;
    t_tag_t [1:0]    t_nf, t_ctag;
    logic [3:0]      t_cnt;

    phys_freelist #(.NUM_PREGS(NUM_PREGS_GPR), .NUM_AREGS(NUM_AREGS_GPR)) u_gpr (
        .clk(clk), .rst(rst), .recovery_en(g_rec), .alloc_req(g_req), .freelist_en(g_en),
        .next_free(g_nf), .alloc_stall(g_stall), .commit_en(g_cen), .commit_tag(g_ctag),
        .commit_alloc(g_cal), .free_count(g_cnt), .overflow_err(g_ovf));

    phys_freelist #(.NUM_PREGS(NUM_PREGS_T), .NUM_AREGS(NUM_AREGS_T)) u_t (
        .clk(clk), .rst(rst), .recovery_en(t_rec), .alloc_req(t_req), .freelist_en(t_en),
        .next_free(t_nf), .alloc_stall(t_stall), .commit_en(t_cen), .commit_tag(t_ctag),
        .commit_alloc(t_cal), .free_count(t_cnt), .overflow_err(t_ovf));

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [1:0] o_en;
    logic       o_stall, o_ovf;
    int         o_nf0, o_nf1, o_cnt;

    always_comb begin
        if (sel == 0) begin
            o_en = g_en; o_stall = g_stall; o_ovf = g_ovf;
            o_nf0 = int'(g_nf[0]); o_nf1 = int'(g_nf[1]); o_cnt = int'(g_cnt);
        end else begin
            o_en = t_en; o_stall = t_stall; o_ovf = t_ovf;
            o_nf0 = int'(t_nf[0]); o_nf1 = int'(t_nf[1]); o_cnt = int'(t_cnt);
        end
    end

    // Model: mq holds every tag from the committed head to the tail; the first moff
    // of them are handed out speculatively.
    int         mq[$];
    int         moff, mdepth;
    logic       movf;
    logic       a_rec;
    logic [1:0] a_req, a_cen, a_cal;
    int         a_t0, a_t1;
    logic [1:0] e_en;
    logic       e_stall;
    int         e_nf0, e_nf1;

    task automatic model_init();
        int areg;
        mdepth = (sel == 0) ? 16 : 15;
        areg   = (sel == 0) ? 16 : 1;
        mq.delete();
        for (int i = 0; i < mdepth; i++) mq.push_back(areg + i);
        moff = 0;
        movf = 1'b0;
    endtask

    task automatic apply(input logic rec, input logic [1:0] req, input logic [1:0] cen,
                         input int t0, input int t1, input logic [1:0] cal);
        int nreq, avail;
        a_rec = rec; a_req = req; a_cen = cen; a_cal = cal; a_t0 = t0; a_t1 = t1;
        g_rec = (sel == 0) && rec;  t_rec = (sel == 1) && rec;
        g_req = (sel == 0) ? req : 2'b00;  t_req = (sel == 1) ? req : 2'b00;
        g_cen = (sel == 0) ? cen : 2'b00;  t_cen = (sel == 1) ? cen : 2'b00;
        g_cal = (sel == 0) ? cal : 2'b00;  t_cal = (sel == 1) ? cal : 2'b00;
        g_ctag[0] = preg_tag_t'(t0); g_ctag[1] = preg_tag_t'(t1);
        t_ctag[0] = t_tag_t'(t0);    t_ctag[1] = t_tag_t'(t1);
        nreq    = int'(req[0]) + int'(req[1]);
        avail   = mq.size() - moff;
        e_stall = (nreq > avail);
        e_en    = (rec || e_stall) ? 2'b00 : req;
        e_nf0   = (avail > 0) ? mq[moff] : -1;
        e_nf1   = (req == 2'b11 && avail > 1) ? mq[moff + 1] : e_nf0;
        #1;
    endtask

    task automatic tick();
        int ncal;
        @(posedge clk);
        moff += int'(e_en[0]) + int'(e_en[1]);
        ncal = int'(a_cal[0]) + int'(a_cal[1]);
        for (int k = 0; k < ncal; k++) begin
            void'(mq.pop_front());
            moff--;
        end
        if (a_cen[0]) begin
            if (mq.size() < mdepth) mq.push_back(a_t0); else movf = 1'b1;
        end
        if (a_cen[1]) begin
            if (mq.size() < mdepth) mq.push_back(a_t1); else movf = 1'b1;
        end
        if (a_rec) moff = 0;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b00);
            tick();
        end
    endtask

    task automatic do_reset(input int s);
        sel = s;
        rst = 1'b0;
        apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        model_init();
        #1;
    endtask

    task automatic test_reset();
        do_reset(0);
        checks++;
        if (o_cnt !== 16 || o_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_gpr_cnt: cnt=%0d ovf=%b, expected 16/0", o_cnt, o_ovf);
        end
        checks++;
        if (o_en !== 2'b00 || o_stall !== 1'b0 || o_nf0 !== 16 || o_nf1 !== 17) begin
            errors++; $display("FAIL reset_gpr_out: en=%b stall=%b nf={%0d,%0d}, expected 00/0/{17,16}",
                               o_en, o_stall, o_nf1, o_nf0);
        end
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b00);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (o_cnt !== 16 || o_nf0 !== 16 || o_nf1 !== 17) begin
            errors++; $display("FAIL reset_midop: cnt=%0d nf={%0d,%0d}, expected 16/{17,16}", o_cnt, o_nf1, o_nf0);
        end
        @(negedge clk);
        rst = 1'b1;
        do_reset(1);
        checks++;
        if (o_cnt !== 15 || o_nf0 !== 1 || o_nf1 !== 2 || o_en !== 2'b00) begin
            errors++; $display("FAIL reset_tbit: cnt=%0d nf={%0d,%0d} en=%b, expected 15/{2,1}/00",
                               o_cnt, o_nf1, o_nf0, o_en);
        end
    endtask

    task automatic test_first_grant();
        do_reset(0);
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_en !== 2'b11 || o_nf0 !== 16 || o_nf1 !== 17) begin
            errors++; $display("FAIL first_grant: en=%b nf={%0d,%0d}, expected 11/{17,16}", o_en, o_nf1, o_nf0);
        end
        tick();
        checks++;
        if (o_cnt !== 14) begin
            errors++; $display("FAIL first_grant_cnt: cnt=%0d, expected 14", o_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset(0);
        for (int i = 0; i < 7; i++) begin
            apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        end
        apply(1'b0, 2'b01, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_stall !== 1'b1 || o_en !== 2'b00) begin
            errors++; $display("FAIL stall_partial: stall=%b en=%b, expected 1/00", o_stall, o_en);
        end
        tick();
        apply(1'b0, 2'b01, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_stall !== 1'b0 || o_en !== 2'b01 || o_nf0 !== 31) begin
            errors++; $display("FAIL stall_last: stall=%b en=%b nf0=%0d, expected 0/01/31", o_stall, o_en, o_nf0);
        end
        tick();
        apply(1'b0, 2'b10, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_stall !== 1'b1 || o_en !== 2'b00 || o_cnt !== 0) begin
            errors++; $display("FAIL stall_empty: stall=%b en=%b cnt=%0d, expected 1/00/0", o_stall, o_en, o_cnt);
        end
        tick();
    endtask

    task automatic test_compaction_release();
        do_reset(0);
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b0, 2'b10, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_en !== 2'b10 || o_nf1 !== 18) begin
            errors++; $display("FAIL compact_slot1: en=%b nf1=%0d, expected 10/18", o_en, o_nf1);
        end
        tick();
        apply(1'b0, 2'b01, 2'b11, 3, 5, 2'b11);
        checks++;
        if (o_en !== 2'b01 || o_nf0 !== 19) begin
            errors++; $display("FAIL release_grant: en=%b nf0=%0d, expected 01/19", o_en, o_nf0);
        end
        tick();
        checks++;
        if (o_cnt !== 14 || o_ovf !== 1'b0) begin
            errors++; $display("FAIL release_cnt: cnt=%0d ovf=%b, expected 14/0", o_cnt, o_ovf);
        end
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        end
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_en !== 2'b11 || o_nf0 !== 3 || o_nf1 !== 5) begin
            errors++; $display("FAIL release_order: en=%b nf={%0d,%0d}, expected 11/{5,3}", o_en, o_nf1, o_nf0);
        end
        tick();
    endtask

    task automatic test_recovery();
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        end
        apply(1'b0, 2'b00, 2'b00, 0, 0, 2'b11); tick();
        apply(1'b1, 2'b00, 2'b00, 0, 0, 2'b00); tick();
        checks++;
        if (o_cnt !== 14) begin
            errors++; $display("FAIL recovery_cnt: cnt=%0d, expected 14", o_cnt);
        end
        apply(1'b0, 2'b01, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_en !== 2'b01 || o_nf0 !== 18) begin
            errors++; $display("FAIL recovery_tag: en=%b nf0=%0d, expected 01/18", o_en, o_nf0);
        end
        tick();
    endtask

    task automatic test_recovery_collision();
        do_reset(0);
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00); tick();
        apply(1'b1, 2'b11, 2'b01, 9, 0, 2'b01);
        checks++;
        if (o_en !== 2'b00) begin
            errors++; $display("FAIL recov_coll_en: en=%b, expected 00", o_en);
        end
        tick();
        checks++;
        if (o_cnt !== 16 || o_ovf !== 1'b0 || o_cnt !== mq.size() - moff) begin
            errors++; $display("FAIL recov_coll_cnt: cnt=%0d ovf=%b, expected 16/0", o_cnt, o_ovf);
        end
    endtask

    task automatic test_overflow();
        do_reset(0);
        apply(1'b0, 2'b00, 2'b01, 7, 0, 2'b00); tick();
        checks++;
        if (o_ovf !== 1'b1 || o_cnt !== 16) begin
            errors++; $display("FAIL overflow_set: ovf=%b cnt=%0d, expected 1/16", o_ovf, o_cnt);
        end
        idle(5);
        apply(1'b0, 2'b11, 2'b00, 0, 0, 2'b00);
        checks++;
        if (o_ovf !== 1'b1 || o_nf0 !== 16 || o_nf1 !== 17) begin
            errors++; $display("FAIL overflow_sticky: ovf=%b nf={%0d,%0d}, expected 1/{17,16}", o_ovf, o_nf1, o_nf0);
        end
        tick();
    endtask

    task automatic test_random_gpr();
        int k, t0, t1;
        logic [1:0] cal, req;
        logic rec;
        do_reset(0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            k   = $urandom_range(0, (moff < 2) ? moff : 2);
            cal = (k == 2) ? 2'b11 : ((k == 1) ? (($urandom % 2) ? 2'b01 : 2'b10) : 2'b00);
            t0  = (moff > 0) ? mq[0] : 0;
            t1  = (k == 2) ? mq[1] : t0;
            req = 2'($urandom);
            rec = ($urandom_range(0, 15) == 0);
            apply(rec, req, cal, t0, t1, cal);
            checks++;
            if (o_en !== e_en || o_stall !== e_stall) begin
                errors++; $display("FAIL rnd_grant cyc %0d: en=%b stall=%b, expected %b/%b", cyc, o_en, o_stall, e_en, e_stall);
            end
            if (e_en[0]) begin
                checks++;
                if (o_nf0 !== e_nf0) begin
                    errors++; $display("FAIL rnd_tag0 cyc %0d: got %0d, expected %0d", cyc, o_nf0, e_nf0);
                end
            end
            if (e_en[1]) begin
                checks++;
                if (o_nf1 !== e_nf1) begin
                    errors++; $display("FAIL rnd_tag1 cyc %0d: got %0d, expected %0d", cyc, o_nf1, e_nf1);
                end
            end
            tick();
            checks++;
            if (o_cnt !== mq.size() - moff || o_ovf !== movf) begin
                errors++; $display("FAIL rnd_cnt cyc %0d: cnt=%0d ovf=%b, expected %0d/%b",
                                   cyc, o_cnt, o_ovf, mq.size() - moff, movf);
            end
        end
    endtask

    task automatic test_tbit_wrap();
        int k, t0, t1;
        logic [1:0] cal, req;
        bit out_tag[16];
        do_reset(1);
        foreach (out_tag[i]) out_tag[i] = 1'b0;
        out_tag[0] = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            k   = $urandom_range(0, (moff < 2) ? moff : 2);
            cal = (k == 2) ? 2'b11 : ((k == 1) ? (($urandom % 2) ? 2'b01 : 2'b10) : 2'b00);
            t0  = (moff > 0) ? mq[0] : 0;
            t1  = (k == 2) ? mq[1] : t0;
            req = (cyc < 280) ? 2'($urandom) : 2'b00;
            apply(1'b0, req, cal, t0, t1, cal);
            checks++;
            if (o_en !== e_en || (e_en[0] && o_nf0 !== e_nf0) || (e_en[1] && o_nf1 !== e_nf1)) begin
                errors++; $display("FAIL tbit_grant cyc %0d: en=%b nf={%0d,%0d}, expected %b/{%0d,%0d}",
                                   cyc, o_en, o_nf1, o_nf0, e_en, e_nf1, e_nf0);
            end
            for (int s = 0; s < 2; s++) begin
                if (o_en[s]) begin
                    checks++;
                    if (out_tag[(s == 0) ? o_nf0 : o_nf1]) begin
                        errors++; $display("FAIL tbit_dup cyc %0d: tag %0d handed out twice", cyc, (s == 0) ? o_nf0 : o_nf1);
                    end
                    out_tag[(s == 0) ? o_nf0 : o_nf1] = 1'b1;
                end
            end
            if (cal[0]) out_tag[t0] = 1'b0;
            if (cal[1]) out_tag[t1] = 1'b0;
            tick();
            checks++;
            if (o_cnt !== mq.size() - moff || o_ovf !== 1'b0) begin
                errors++; $display("FAIL tbit_cnt cyc %0d: cnt=%0d ovf=%b, expected %0d/0", cyc, o_cnt, o_ovf, mq.size() - moff);
            end
        end
        while (moff > 0) begin
            cal = (moff >= 2) ? 2'b11 : 2'b01;
            t0  = mq[0];
            t1  = (moff >= 2) ? mq[1] : t0;
            if (cal[0]) out_tag[t0] = 1'b0;
            if (cal[1]) out_tag[t1] = 1'b0;
            apply(1'b0, 2'b00, cal, t0, t1, cal);
            tick();
        end
        checks++;
        if (o_cnt !== 15) begin
            errors++; $display("FAIL tbit_lost: cnt=%0d, expected 15", o_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, (i == 7) ? 2'b01 : 2'b11, 2'b00, 0, 0, 2'b00);
            for (int s = 0; s < 2; s++) begin
                if (o_en[s]) begin
                    checks++;
                    if (out_tag[(s == 0) ? o_nf0 : o_nf1]) begin
                        errors++; $display("FAIL tbit_drain_dup: tag %0d repeated", (s == 0) ? o_nf0 : o_nf1);
                    end
                    out_tag[(s == 0) ? o_nf0 : o_nf1] = 1'b1;
                end
            end
            tick();
        end
        checks++;
        if (o_cnt !== 0) begin
            errors++; $display("FAIL tbit_drain_cnt: cnt=%0d, expected 0", o_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_grant();
        test_stall();
        test_compaction_release();
        test_recovery();
        test_recovery_collision();
        test_overflow();
        test_random_gpr();
        test_tbit_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
